// File: rtl/fixed_conv_monitor.sv
// Multi-channel convergence monitor for the fixed-point gradient-descent loop.
// Declares convergence after STABLE_CNT all-in-tolerance iterations, timeout after MAX_ITER.
module fixed_conv_monitor #(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 8,
  parameter int CHANNELS   = 4,
  parameter int STABLE_CNT = 3,
  parameter int MAX_ITER   = 1024,
  parameter int ITER_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-2:0]             tol_in,
  input  logic                         in_valid,
  input  logic [CHANNELS*WIDTH-1:0]    cur_in,
  input  logic [CHANNELS*WIDTH-1:0]    prev_in,
  output logic [CHANNELS-1:0]          ch_conv,
  output logic                         converged,
  output logic                         timeout,
  output logic                         done,
  output logic                         busy,
  output logic [ITER_W-1:0]            iter_count
);

  localparam int SC_W = $clog2(STABLE_CNT + 1);

  typedef enum logic [1:0] {IDLE, RUN, CONV, TMO} state_t;

  state_t                 state;
  logic [WIDTH-2:0]       tol;
  logic [SC_W-1:0]        stable;
  logic [SC_W-1:0]        stable_next;
  logic [ITER_W-1:0]      iter_next;
  logic [CHANNELS-1:0]    in_tol;
  logic signed [WIDTH:0]  cur_x;
  logic signed [WIDTH:0]  prev_x;
  logic signed [WIDTH:0]  diff;
  logic signed [WIDTH:0]  tol_s;

  generate
    if (FRAC >= WIDTH || STABLE_CNT < 1 || MAX_ITER < 1 || $clog2(MAX_ITER + 1) > ITER_W) begin : g_param_check
      $error("fixed_conv_monitor: inconsistent parameters");
    end
  endgenerate

  // One extra bit keeps the difference of two full-range words from wrapping.
  always_comb begin
    in_tol = '0;
    cur_x  = '0;
    prev_x = '0;
    diff   = '0;
    tol_s  = {2'b00, tol};
    for (int k = 0; k < CHANNELS; k++) begin
      cur_x     = {cur_in[k*WIDTH+WIDTH-1], cur_in[k*WIDTH +: WIDTH]};
      prev_x    = {prev_in[k*WIDTH+WIDTH-1], prev_in[k*WIDTH +: WIDTH]};
      diff      = cur_x - prev_x;
      in_tol[k] = (diff > -tol_s) && (diff < tol_s);
    end
  end

  always_comb begin
    iter_next = iter_count + ITER_W'(1);
    if (!(&in_tol))
      stable_next = '0;
    else if (stable == SC_W'(STABLE_CNT))
      stable_next = stable;
    else
      stable_next = stable + SC_W'(1);
  end

  // Convergence is tested before timeout so a sample satisfying both converges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tol        <= '0;
      stable     <= '0;
      iter_count <= '0;
      ch_conv    <= '0;
      converged  <= 1'b0;
      timeout    <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else if (start) begin
      state      <= RUN;
      tol        <= tol_in;
      stable     <= '0;
      iter_count <= '0;
      ch_conv    <= '0;
      converged  <= 1'b0;
      timeout    <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (in_valid) begin
            ch_conv    <= in_tol;
            iter_count <= iter_next;
            stable     <= stable_next;
            if (stable_next == SC_W'(STABLE_CNT)) begin
              state     <= CONV;
              converged <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else if (iter_next == ITER_W'(MAX_ITER)) begin
              state   <= TMO;
              timeout <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_conv_monitor.sv
// Randomised self-checking bench for fixed_conv_monitor against a run-level reference model.
// Uses MAX_ITER=8 so timeout and convergence-on-the-last-sample fit one instance.
module tb_fixed_conv_monitor;

  localparam int W    = 32;
  localparam int CH   = 4;
  localparam int SC   = 3;
  localparam int MI   = 8;
  localparam int IW   = 16;
  localparam int ST_W = CH + 4 + IW;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [W-2:0]      tol_in;
  logic              in_valid;
  logic [CH*W-1:0]   cur_in;
  logic [CH*W-1:0]   prev_in;
  logic [CH-1:0]     ch_conv;
  logic              converged;
  logic              timeout;
  logic              done;
  logic              busy;
  logic [IW-1:0]     iter_count;

  int checks   = 0;
  int failures = 0;

  bit        m_busy, m_conv, m_tmo;
  int        m_iter, m_streak;
  bit [CH-1:0] m_ch;
  longint    m_tol;

  fixed_conv_monitor #(
    .WIDTH(W), .FRAC(8), .CHANNELS(CH), .STABLE_CNT(SC), .MAX_ITER(MI), .ITER_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tol_in(tol_in), .in_valid(in_valid),
    .cur_in(cur_in), .prev_in(prev_in), .ch_conv(ch_conv), .converged(converged),
    .timeout(timeout), .done(done), .busy(busy), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  wire [ST_W-1:0] dut_status = {ch_conv, converged, timeout, done, busy, iter_count};

  function automatic logic [ST_W-1:0] exp_status();
    return {m_ch, m_conv, m_tmo, m_conv | m_tmo, m_busy, IW'(m_iter)};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_conv = 0; m_tmo = 0; m_iter = 0; m_streak = 0; m_ch = '0; m_tol = 0;
  endtask

  // A run is a count of accepted samples plus a streak of fully in-tolerance ones.
  task automatic model_step(input bit st, input logic [W-2:0] tol, input bit v,
                            input logic [CH*W-1:0] c, input logic [CH*W-1:0] p);
    longint d;
    bit all_in;
    if (st) begin
      model_reset();
      m_busy = 1;
      m_tol  = longint'(tol);
    end else if (m_busy && v) begin
      all_in = 1;
      for (int k = 0; k < CH; k++) begin
        d = longint'($signed(c[k*W +: W])) - longint'($signed(p[k*W +: W]));
        m_ch[k] = (d > -m_tol) && (d < m_tol);
        all_in &= m_ch[k];
      end
      m_iter++;
      m_streak = all_in ? ((m_streak < SC) ? m_streak + 1 : SC) : 0;
      if (m_streak == SC) begin
        m_conv = 1; m_busy = 0;
      end else if (m_iter == MI) begin
        m_tmo = 1; m_busy = 0;
      end
    end
  endtask

  // Called at a negedge; the following posedge consumes the inputs.
  task automatic step(input bit st, input logic [W-2:0] tol, input bit v,
                      input logic [CH*W-1:0] c, input logic [CH*W-1:0] p);
    start = st; tol_in = tol; in_valid = v; cur_in = c; prev_in = p;
    model_step(st, tol, v, c, p);
    @(negedge clk);
    start = 0; in_valid = 0;
  endtask

  task automatic build(input longint d0, d1, d2, d3,
                       output logic [CH*W-1:0] c, output logic [CH*W-1:0] p);
    longint d [CH];
    int pv;
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < CH; k++) begin
      pv = int'($urandom_range(0, 1 << 21)) - (1 << 20);
      p[k*W +: W] = W'(pv);
      c[k*W +: W] = W'(longint'(pv) + d[k]);
    end
  endtask

  task automatic sample(input longint d0, d1, d2, d3);
    logic [CH*W-1:0] c, p;
    build(d0, d1, d2, d3, c, p);
    step(0, W'($urandom_range(0, 255)), 1, c, p);
  endtask

  task automatic do_start(input int tol);
    step(1, (W-1)'(tol), 0, '0, '0);
  endtask

  function automatic longint gen_diff(input int tol, input bit inside_tol);
    longint mag;
    if (inside_tol && tol > 0)
      return longint'($urandom_range(0, 2*tol - 2)) - longint'(tol - 1);
    mag = longint'(tol) + longint'($urandom_range(0, 50));
    return $urandom_range(0, 1) ? mag : -mag;
  endfunction

  task automatic test_reset();
    rst = 1; start = 0; in_valid = 0; tol_in = '0; cur_in = '0; prev_in = '0;
    model_reset();
    #2;
    checks++;
    if (dut_status !== '0) begin
      failures++; $display("[TB] FAIL reset_outputs: got %h expected %h", dut_status, {ST_W{1'b0}});
    end
    @(negedge clk);
    rst = 0;
    sample(0, 0, 0, 0);
    checks++;
    if (iter_count !== 0 || dut_status !== exp_status()) begin
      failures++; $display("[TB] FAIL idle_ignores_valid: got %h expected %h", dut_status, exp_status());
    end
  endtask

  task automatic test_basic_conv();
    do_start(16);
    checks++;
    if (busy !== 1'b1 || dut_status !== exp_status()) begin
      failures++; $display("[TB] FAIL start_busy: got %h expected %h", dut_status, exp_status());
    end
    for (int i = 0; i < 3; i++) begin
      sample(15, -15, 0, 1);
      checks++;
      if (ch_conv !== 4'hF || converged !== (i == 2) || dut_status !== exp_status()) begin
        failures++; $display("[TB] FAIL basic_sample%0d: got %h expected %h", i, dut_status, exp_status());
      end
    end
    checks++;
    if (converged !== 1'b1 || done !== 1'b1 || timeout !== 1'b0 || iter_count !== 3) begin
      failures++; $display("[TB] FAIL basic_converged: got conv=%b done=%b iter=%0d expected 1 1 3", converged, done, iter_count);
    end
    sample(500, 0, 0, 0);
    checks++;
    if (iter_count !== 3 || ch_conv !== 4'hF || dut_status !== exp_status()) begin
      failures++; $display("[TB] FAIL conv_frozen: got %h expected %h", dut_status, exp_status());
    end
  endtask

  task automatic test_boundary();
    do_start(16);
    sample(16, 3, -3, 0);
    checks++;
    if (ch_conv !== 4'hE || dut_status !== exp_status()) begin
      failures++; $display("[TB] FAIL bound_plus16: got %h expected %h", dut_status, exp_status());
    end
    sample(-16, 0, 0, 0);
    checks++;
    if (ch_conv !== 4'hE || dut_status !== exp_status()) begin
      failures++; $display("[TB] FAIL bound_minus16: got %h expected %h", dut_status, exp_status());
    end
    sample(15, 0, 0, 0);
    sample(-15, 0, 0, 0);
    checks++;
    if (converged !== 1'b0 || ch_conv !== 4'hF || dut_status !== exp_status()) begin
      failures++; $display("[TB] FAIL bound_streak_reset: got %h expected %h", dut_status, exp_status());
    end
  endtask

  task automatic test_stability_reset();
    do_start(16);
    for (int i = 0; i < 6; i++) begin
      sample(gen_diff(16, 1), gen_diff(16, 1), (i == 2) ? 40 : gen_diff(16, 1), gen_diff(16, 1));
      checks++;
      if (converged !== (i == 5) || dut_status !== exp_status()) begin
        failures++; $display("[TB] FAIL stab_sample%0d: got %h expected %h", i, dut_status, exp_status());
      end
    end
    checks++;
    if (iter_count !== 6) begin
      failures++; $display("[TB] FAIL stab_iter: got %0d expected 6", iter_count);
    end
  endtask

  task automatic test_timeout();
    do_start(16);
    for (int i = 0; i < MI; i++) begin
      sample(gen_diff(16, 1), gen_diff(16, 0), gen_diff(16, 1), gen_diff(16, 1));
      checks++;
      if (timeout !== (i == MI - 1) || converged !== 1'b0 || dut_status !== exp_status()) begin
        failures++; $display("[TB] FAIL tmo_sample%0d: got %h expected %h", i, dut_status, exp_status());
      end
    end
    sample(0, 0, 0, 0);
    sample(0, 0, 0, 0);
    checks++;
    if (iter_count !== MI || timeout !== 1'b1 || done !== 1'b1 || dut_status !== exp_status()) begin
      failures++; $display("[TB] FAIL tmo_frozen: got %h expected %h", dut_status, exp_status());
    end
  endtask

  task automatic test_simultaneous();
    int ch;
    do_start(16);
    for (int i = 0; i < MI; i++) begin
      ch = $urandom_range(0, CH - 1);
      if (i < MI - SC)
        sample(gen_diff(16, ch != 0), gen_diff(16, ch != 1), gen_diff(16, ch != 2), gen_diff(16, ch != 3));
      else
        sample(gen_diff(16, 1), gen_diff(16, 1), gen_diff(16, 1), gen_diff(16, 1));
    end
    checks++;
    if (converged !== 1'b1 || timeout !== 1'b0 || iter_count !== MI || dut_status !== exp_status()) begin
      failures++; $display("[TB] FAIL simultaneous: got %h expected %h", dut_status, exp_status());
    end
  endtask

  task automatic test_overflow();
    logic [CH*W-1:0] c, p;
    do_start(16);
    c = '0; p = '0;
    c[W-1:0] = 32'h7FFF_FFFF; p[W-1:0] = 32'h8000_0000;
    step(0, '0, 1, c, p);
    checks++;
    if (ch_conv !== 4'hE || dut_status !== exp_status()) begin
      failures++; $display("[TB] FAIL ovf_pos: got %h expected %h", dut_status, exp_status());
    end
    c[W-1:0] = 32'h8000_0000; p[W-1:0] = 32'h7FFF_FFFF;
    step(0, '0, 1, c, p);
    checks++;
    if (ch_conv !== 4'hE || dut_status !== exp_status()) begin
      failures++; $display("[TB] FAIL ovf_neg: got %h expected %h", dut_status, exp_status());
    end
  endtask

  task automatic test_async_reset();
    logic [CH*W-1:0] c, p;
    do_start(16);
    sample(1, 2, 3, 4);
    sample(-1, -2, -3, -4);
    #2 rst = 1;
    #1;
    model_reset();
    checks++;
    if (dut_status !== '0) begin
      failures++; $display("[TB] FAIL async_reset: got %h expected %h", dut_status, {ST_W{1'b0}});
    end
    @(negedge clk);
    rst = 0;
    build(0, 1, 2, 3, c, p);
    step(1, 16, 1, c, p);
    checks++;
    if (iter_count !== 0 || ch_conv !== 4'h0 || busy !== 1'b1 || dut_status !== exp_status()) begin
      failures++; $display("[TB] FAIL start_drops_sample: got %h expected %h", dut_status, exp_status());
    end
  endtask

  task automatic test_back_to_back();
    logic [CH*W-1:0] c, p;
    int  tol;
    bit  v, st;
    for (int run = 0; run < 8; run++) begin
      tol = (run == 0) ? 0 : int'($urandom_range(1, 64));
      do_start(tol);
      for (int cyc = 0; cyc < 30; cyc++) begin
        build(gen_diff(tol, $urandom_range(0, 9) != 0), gen_diff(tol, $urandom_range(0, 9) != 0),
              gen_diff(tol, $urandom_range(0, 9) != 0), gen_diff(tol, $urandom_range(0, 9) != 0), c, p);
        v  = $urandom_range(0, 3) != 0;
        st = $urandom_range(0, 39) == 0;
        step(st, (W-1)'(tol), v, c, p);
        checks++;
        if (dut_status !== exp_status()) begin
          failures++; $display("[TB] FAIL rand_r%0d_c%0d: got %h expected %h", run, cyc, dut_status, exp_status());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_conv();
    test_boundary();
    test_stability_reset();
    test_timeout();
    test_simultaneous();
    test_overflow();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
